// File: rtl/am_pkg.sv
// Shared constants, widths and types for the associative-memory search controller.
package am_pkg;

  localparam int unsigned HV_DIM      = 5000;
  localparam int unsigned DIMS_PER_CC = 500;
  localparam int unsigned NUM_SEGS    = HV_DIM / DIMS_PER_CC;
  localparam int unsigned NUM_CLASSES = 26;

  localparam int unsigned CLASS_W = $clog2(NUM_CLASSES);
  localparam int unsigned SIM_W   = $clog2(HV_DIM + 1);
  localparam int unsigned ADDR_W  = $clog2(NUM_CLASSES * NUM_SEGS);
  localparam int unsigned POP_W   = $clog2(DIMS_PER_CC + 1);
  localparam int unsigned SEG_W   = 4;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} am_state_e;

  typedef logic [SIM_W-1:0]   sim_t;
  typedef logic [CLASS_W-1:0] class_idx_t;

endpackage

// File: rtl/seg_popcount.sv
// Bitwise AND of a query segment with a class segment, followed by a population count.
module seg_popcount
  import am_pkg::*;
(
  input  logic [DIMS_PER_CC-1:0] a,
  input  logic [DIMS_PER_CC-1:0] b,
  output logic [POP_W-1:0]       pop_c
);

  always_comb begin
    pop_c = '0;
    for (int i = 0; i < int'(DIMS_PER_CC); i++) begin
      pop_c = pop_c + POP_W'(a[i] & b[i]);
    end
  end

endmodule

// File: rtl/am_search_ctrl.sv
// Walks all class/segment pairs of the AM, accumulates per-class overlap with the
// query hypervector and reports the best-matching class.
module am_search_ctrl
  import am_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   abort,
  output logic                   busy,
  output logic                   testing_hdc_model,
  output logic [SEG_W-1:0]       query_ctr,
  input  logic [DIMS_PER_CC-1:0] query_hv_segment,
  output logic                   am_rd_en,
  output logic [ADDR_W-1:0]      am_rd_addr,
  input  logic [DIMS_PER_CC-1:0] am_rd_data,
  output logic                   done,
  output class_idx_t             pred_class,
  output sim_t                   pred_sim
);

  am_state_e             state_q, state_d;
  logic [SEG_W-1:0]      seg_d;
  class_idx_t            cls_q, cls_d;
  logic [ADDR_W-1:0]     addr_d;
  logic                  rd_en_d, busy_d, done_d;
  logic [DIMS_PER_CC-1:0] query_q, query_d;
  logic                  cmp_vld_q, cmp_vld_d;
  logic                  cmp_last_q, cmp_last_d;
  class_idx_t            cmp_cls_q, cmp_cls_d;
  sim_t                  acc_q, acc_d;
  sim_t                  best_sim_q, best_sim_d;
  class_idx_t            best_cls_q, best_cls_d;
  class_idx_t            pred_class_d;
  sim_t                  pred_sim_d;
  logic [POP_W-1:0]      pop_c;
  sim_t                  total_c;
  logic                  last_seg_c, last_cls_c;

  seg_popcount u_pop (
    .a     (query_q),
    .b     (am_rd_data),
    .pop_c (pop_c)
  );

  assign testing_hdc_model = busy;

  always_comb begin
    state_d      = state_q;
    seg_d        = query_ctr;
    cls_d        = cls_q;
    addr_d       = am_rd_addr;
    rd_en_d      = 1'b0;
    busy_d       = busy;
    done_d       = 1'b0;
    query_d      = query_q;
    cmp_vld_d    = 1'b0;
    cmp_last_d   = 1'b0;
    cmp_cls_d    = cmp_cls_q;
    acc_d        = acc_q;
    best_sim_d   = best_sim_q;
    best_cls_d   = best_cls_q;
    pred_class_d = pred_class;
    pred_sim_d   = pred_sim;

    total_c    = acc_q + SIM_W'(pop_c);
    last_seg_c = (query_ctr == SEG_W'(NUM_SEGS - 1));
    last_cls_c = (cls_q == CLASS_W'(NUM_CLASSES - 1));

    // Compute stage: read data for the previous issue is valid this cycle.
    if (cmp_vld_q) begin
      if (cmp_last_q) begin
        acc_d = '0;
        if (total_c > best_sim_q) begin
          best_sim_d = total_c;
          best_cls_d = cmp_cls_q;
        end
      end else begin
        acc_d = total_c;
      end
    end

    unique case (state_q)
      IDLE: begin
        if (start && !abort) begin
          state_d    = ISSUE;
          busy_d     = 1'b1;
          rd_en_d    = 1'b1;
          seg_d      = '0;
          cls_d      = '0;
          addr_d     = '0;
          acc_d      = '0;
          best_sim_d = '0;
          best_cls_d = '0;
        end
      end
      ISSUE: begin
        query_d    = query_hv_segment;
        cmp_vld_d  = 1'b1;
        cmp_last_d = last_seg_c;
        cmp_cls_d  = cls_q;
        addr_d     = am_rd_addr + ADDR_W'(1);
        rd_en_d    = 1'b1;
        if (!last_seg_c) begin
          seg_d = query_ctr + SEG_W'(1);
        end else if (!last_cls_c) begin
          seg_d = '0;
          cls_d = cls_q + CLASS_W'(1);
        end else begin
          state_d = DRAIN;
          rd_en_d = 1'b0;
          seg_d   = '0;
          cls_d   = '0;
          addr_d  = '0;
        end
      end
      DRAIN: begin
        // Final compute lands this edge, so load results from the updated best.
        state_d      = DONE;
        done_d       = 1'b1;
        pred_class_d = best_cls_d;
        pred_sim_d   = best_sim_d;
      end
      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase

    if (abort && (state_q == ISSUE || state_q == DRAIN)) begin
      state_d      = IDLE;
      busy_d       = 1'b0;
      rd_en_d      = 1'b0;
      done_d       = 1'b0;
      seg_d        = '0;
      cls_d        = '0;
      addr_d       = '0;
      cmp_vld_d    = 1'b0;
      pred_class_d = pred_class;
      pred_sim_d   = pred_sim;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      query_ctr  <= '0;
      cls_q      <= '0;
      am_rd_addr <= '0;
      am_rd_en   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      query_q    <= '0;
      cmp_vld_q  <= 1'b0;
      cmp_last_q <= 1'b0;
      cmp_cls_q  <= '0;
      acc_q      <= '0;
      best_sim_q <= '0;
      best_cls_q <= '0;
      pred_class <= '0;
      pred_sim   <= '0;
    end else begin
      state_q    <= state_d;
      query_ctr  <= seg_d;
      cls_q      <= cls_d;
      am_rd_addr <= addr_d;
      am_rd_en   <= rd_en_d;
      busy       <= busy_d;
      done       <= done_d;
      query_q    <= query_d;
      cmp_vld_q  <= cmp_vld_d;
      cmp_last_q <= cmp_last_d;
      cmp_cls_q  <= cmp_cls_d;
      acc_q      <= acc_d;
      best_sim_q <= best_sim_d;
      best_cls_q <= best_cls_d;
      pred_class <= pred_class_d;
      pred_sim   <= pred_sim_d;
    end
  end

endmodule

// File: tb/tb_am_search_ctrl.sv
// Randomized bench for am_search_ctrl with a class-similarity reference model.
module tb_am_search_ctrl;
  import am_pkg::*;

  localparam int NWORDS  = int'(NUM_CLASSES * NUM_SEGS);
  localparam int LAT     = NWORDS + 2;
  localparam int RUN_CYC = 300;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic                   start;
  logic                   abort;
  logic                   busy;
  logic                   testing_hdc_model;
  logic [SEG_W-1:0]       query_ctr;
  logic [DIMS_PER_CC-1:0] query_hv_segment;
  logic                   am_rd_en;
  logic [ADDR_W-1:0]      am_rd_addr;
  logic [DIMS_PER_CC-1:0] am_rd_data;
  logic                   done;
  class_idx_t             pred_class;
  sim_t                   pred_sim;

  logic [DIMS_PER_CC-1:0] qry [NUM_SEGS];
  logic [DIMS_PER_CC-1:0] mem [NWORDS];

  int n_chk = 0;
  int n_err = 0;
  int last_cls = 0;
  int last_sim = 0;

  am_search_ctrl dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .start             (start),
    .abort             (abort),
    .busy              (busy),
    .testing_hdc_model (testing_hdc_model),
    .query_ctr         (query_ctr),
    .query_hv_segment  (query_hv_segment),
    .am_rd_en          (am_rd_en),
    .am_rd_addr        (am_rd_addr),
    .am_rd_data        (am_rd_data),
    .done              (done),
    .pred_class        (pred_class),
    .pred_sim          (pred_sim)
  );

  always #5 clk = ~clk;

  assign query_hv_segment = (int'(query_ctr) < int'(NUM_SEGS)) ? qry[query_ctr] : '0;

  // Class memory with one cycle of read latency.
  always @(posedge clk) begin
    if (am_rd_en) am_rd_data <= (int'(am_rd_addr) < NWORDS) ? mem[am_rd_addr] : '0;
  end

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [DIMS_PER_CC-1:0] rnd_seg();
    logic [511:0] t;
    t = '0;
    for (int i = 0; i < 16; i++) t = {t[479:0], $urandom()};
    return t[DIMS_PER_CC-1:0];
  endfunction

  // Similarity = total overlap over all segments; strict max keeps lowest class on ties.
  task automatic model(output int cls, output int sim);
    int tot;
    cls = 0;
    sim = 0;
    for (int c = 0; c < int'(NUM_CLASSES); c++) begin
      tot = 0;
      for (int s = 0; s < int'(NUM_SEGS); s++)
        tot += $countones(qry[s] & mem[c * int'(NUM_SEGS) + s]);
      if (tot > sim) begin
        sim = tot;
        cls = c;
      end
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, ".busy"}, int'(busy), 0);
    chk({tag, ".thm"}, int'(testing_hdc_model), 0);
    chk({tag, ".rd_en"}, int'(am_rd_en), 0);
    chk({tag, ".done"}, int'(done), 0);
    chk({tag, ".qctr"}, int'(query_ctr), 0);
    chk({tag, ".addr"}, int'(am_rd_addr), 0);
    chk({tag, ".pcls"}, int'(pred_class), 0);
    chk({tag, ".psim"}, int'(pred_sim), 0);
  endtask

  task automatic fill_random();
    for (int s = 0; s < int'(NUM_SEGS); s++) qry[s] = rnd_seg();
    for (int w = 0; w < NWORDS; w++) mem[w] = rnd_seg();
  endtask

  // One search; abort_at / restart_at / rst_at are cycle offsets from the start cycle (0 = unused).
  task automatic run(input string tag, input int abort_at, input int restart_at, input int rst_at);
    int exp_cls, exp_sim;
    int done_cnt, done_cyc, en_cnt, seq_err, busy_err;
    int end_cyc;
    bit exp_en;
    model(exp_cls, exp_sim);
    done_cnt = 0; done_cyc = -1; en_cnt = 0; seq_err = 0; busy_err = 0;
    end_cyc  = (abort_at > 0) ? abort_at : LAT;
    start = 1'b1;
    for (int cyc = 1; cyc <= RUN_CYC; cyc++) begin
      @(negedge clk);
      exp_en = (cyc <= NWORDS) && (cyc <= end_cyc);
      if (am_rd_en !== exp_en) seq_err++;
      if (am_rd_en) begin
        en_cnt++;
        if (int'(am_rd_addr) != cyc - 1) seq_err++;
        if (int'(query_ctr) != (cyc - 1) % int'(NUM_SEGS)) seq_err++;
      end else if (query_ctr != '0) begin
        seq_err++;
      end
      if (busy !== (cyc <= end_cyc)) busy_err++;
      if (testing_hdc_model !== busy) busy_err++;
      if (done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      if (abort_at > 0 && cyc == abort_at + 1) begin
        chk({tag, ".abort_busy"}, int'(busy), 0);
        chk({tag, ".abort_en"}, int'(am_rd_en), 0);
      end
      if (cyc == rst_at) begin
        rst_n = 1'b0;
        #1;
        chk_reset({tag, ".async"});
        break;
      end
      start = (cyc == restart_at);
      abort = (cyc == abort_at);
    end
    start = 1'b0;
    abort = 1'b0;
    if (rst_at > 0) begin
      chk({tag, ".seq"}, seq_err, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      last_cls = 0;
      last_sim = 0;
      return;
    end
    chk({tag, ".seq"}, seq_err, 0);
    chk({tag, ".busy"}, busy_err, 0);
    if (abort_at > 0) begin
      chk({tag, ".no_done"}, done_cnt, 0);
      chk({tag, ".keep_cls"}, int'(pred_class), last_cls);
      chk({tag, ".keep_sim"}, int'(pred_sim), last_sim);
    end else begin
      chk({tag, ".done_cnt"}, done_cnt, 1);
      chk({tag, ".done_cyc"}, done_cyc, LAT);
      chk({tag, ".en_cnt"}, en_cnt, NWORDS);
      chk({tag, ".cls"}, int'(pred_class), exp_cls);
      chk({tag, ".sim"}, int'(pred_sim), exp_sim);
      last_cls = exp_cls;
      last_sim = exp_sim;
    end
  endtask

  initial begin
    logic [DIMS_PER_CC-1:0] half;
    rst_n = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    for (int s = 0; s < int'(NUM_SEGS); s++) qry[s] = '0;
    for (int w = 0; w < NWORDS; w++) mem[w] = '0;
    repeat (3) @(negedge clk);
    chk_reset("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Single exact match on class 5.
    for (int s = 0; s < int'(NUM_SEGS); s++) qry[s] = '1;
    for (int s = 0; s < int'(NUM_SEGS); s++) mem[5 * int'(NUM_SEGS) + s] = '1;
    run("match", 0, 0, 0);
    chk("match.cls5", int'(pred_class), 5);
    chk("match.sim5000", int'(pred_sim), int'(HV_DIM));

    // Tie between classes 3 and 7, near miss on 12.
    half = '0;
    for (int i = 0; i < int'(DIMS_PER_CC) / 2; i++) half[i] = 1'b1;
    for (int s = 0; s < int'(NUM_SEGS); s++) qry[s] = half;
    for (int w = 0; w < NWORDS; w++) mem[w] = rnd_seg() & {DIMS_PER_CC{1'b1}} & ~half | (rnd_seg() & half & rnd_seg());
    for (int s = 0; s < int'(NUM_SEGS); s++) begin
      mem[3 * int'(NUM_SEGS) + s]  = half;
      mem[7 * int'(NUM_SEGS) + s]  = half;
      mem[12 * int'(NUM_SEGS) + s] = half;
    end
    mem[12 * int'(NUM_SEGS)][0] = 1'b0;
    run("tie", 0, 0, 0);
    chk("tie.cls3", int'(pred_class), 3);
    chk("tie.sim2500", int'(pred_sim), int'(HV_DIM) / 2);

    for (int k = 0; k < 2; k++) begin
      fill_random();
      run($sformatf("rand%0d", k), 0, 0, 0);
    end

    fill_random();
    run("busy_start", 0, 50, 0);

    fill_random();
    run("abort", 100, 0, 0);
    run("after_abort", 0, 0, 0);

    fill_random();
    run("midrst", 0, 0, 30);
    run("after_rst", 0, 0, 0);

    for (int w = 0; w < NWORDS; w++) mem[w] = '0;
    run("zero", 0, 0, 0);
    chk("zero.cls0", int'(pred_class), 0);
    chk("zero.sim0", int'(pred_sim), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
